// File: rtl/uart_blob_tx.sv
// UART message transmitter: sends the low byte_count bytes of a latched word as 8N1 frames.
// Define UART_BLOB_TX_PARITY_EN to add an even-parity bit to every frame (8E1).
module uart_blob_tx #(
  parameter int DATA_WIDTH              = 1072,
  parameter int BYTE_COUNT_WIDTH        = 8,
  parameter int UART_TICKS_PER_BIT      = 20,
  parameter int UART_TICKS_PER_BIT_SIZE = 5,
  parameter int GAP_TICKS               = 15,
  parameter int GAP_TICKS_WIDTH         = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic [BYTE_COUNT_WIDTH-1:0] byte_count,
  input  logic                        start,
  input  logic                        repeat_en,
  input  logic                        abort,
  output logic                        tx_out,
  output logic                        busy,
  output logic                        done,
  output logic [BYTE_COUNT_WIDTH-1:0] bytes_sent
);

  localparam int MAX_BYTES = DATA_WIDTH / 8;
  localparam logic [BYTE_COUNT_WIDTH-1:0]        MAX_COUNT = BYTE_COUNT_WIDTH'(MAX_BYTES);
  localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] TICK_LAST = UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
  localparam logic [GAP_TICKS_WIDTH-1:0]         GAP_LAST  = GAP_TICKS_WIDTH'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_BLOB_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_GAP
  } state_t;

  state_t                         state_reg, state_next;
  logic [DATA_WIDTH-1:0]          data_reg, data_next;
  logic [BYTE_COUNT_WIDTH-1:0]    count_reg, count_next;
  logic [BYTE_COUNT_WIDTH-1:0]    bytes_sent_reg, bytes_sent_next;
  logic [7:0]                     cur_byte_reg, cur_byte_next;
  logic [UART_TICKS_PER_BIT_SIZE-1:0] tick_reg, tick_next;
  logic [2:0]                     bit_idx_reg, bit_idx_next;
  logic [GAP_TICKS_WIDTH-1:0]     gap_reg, gap_next;
  logic                           tx_reg, tx_next;
  logic                           done_reg, done_next;

  logic [7:0]                     data_bytes [MAX_BYTES];
  logic [BYTE_COUNT_WIDTH-1:0]    sel_idx;
  logic [7:0]                     next_byte;
  logic                           tick_end;

  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_split
    assign data_bytes[gi] = data_reg[8*gi +: 8];
  end

  // The byte after the one currently on the line, ready for the next start bit.
  always_comb begin
    sel_idx   = bytes_sent_reg + BYTE_COUNT_WIDTH'(1);
    next_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (sel_idx == BYTE_COUNT_WIDTH'(i)) next_byte = data_bytes[i];
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      data_reg       <= '0;
      count_reg      <= '0;
      bytes_sent_reg <= '0;
      cur_byte_reg   <= '0;
      tick_reg       <= '0;
      bit_idx_reg    <= '0;
      gap_reg        <= '0;
      tx_reg         <= 1'b1;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      count_reg      <= count_next;
      bytes_sent_reg <= bytes_sent_next;
      cur_byte_reg   <= cur_byte_next;
      tick_reg       <= tick_next;
      bit_idx_reg    <= bit_idx_next;
      gap_reg        <= gap_next;
      tx_reg         <= tx_next;
      done_reg       <= done_next;
    end
  end

  // tx_next is the line level for the state being entered, so the line is registered.
  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    count_next      = count_reg;
    bytes_sent_next = bytes_sent_reg;
    cur_byte_next   = cur_byte_reg;
    tick_next       = tick_reg;
    bit_idx_next    = bit_idx_reg;
    gap_next        = gap_reg;
    tx_next         = tx_reg;
    done_next       = 1'b0;
    tick_end        = (tick_reg == TICK_LAST);

    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (start && !abort) begin
          data_next       = data_in;
          count_next      = (byte_count > MAX_COUNT) ? MAX_COUNT : byte_count;
          bytes_sent_next = '0;
          if (byte_count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next    = S_START;
            tx_next       = 1'b0;
            tick_next     = '0;
            cur_byte_next = data_in[7:0];
          end
        end
      end

      S_START: begin
        tick_next = tick_reg + 1'b1;
        if (tick_end) begin
          tick_next    = '0;
          bit_idx_next = '0;
          state_next   = S_DATA;
          tx_next      = cur_byte_reg[0];
        end
      end

      S_DATA: begin
        tick_next = tick_reg + 1'b1;
        if (tick_end) begin
          tick_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_BLOB_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = ^cur_byte_reg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = cur_byte_reg[bit_idx_next];
          end
        end
      end

`ifdef UART_BLOB_TX_PARITY_EN
      S_PARITY: begin
        tick_next = tick_reg + 1'b1;
        if (tick_end) begin
          tick_next  = '0;
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tick_next = tick_reg + 1'b1;
        if (tick_end) begin
          tick_next       = '0;
          bytes_sent_next = sel_idx;
          if (sel_idx < count_reg) begin
            state_next    = S_START;
            tx_next       = 1'b0;
            cur_byte_next = next_byte;
          end else begin
            state_next = S_GAP;
            gap_next   = '0;
            tx_next    = 1'b1;
            done_next  = 1'b1;
          end
        end
      end

      S_GAP: begin
        tx_next  = 1'b1;
        gap_next = gap_reg + 1'b1;
        if (gap_reg == GAP_LAST) begin
          gap_next = '0;
          if (repeat_en) begin
            state_next      = S_START;
            tx_next         = 1'b0;
            tick_next       = '0;
            bytes_sent_next = '0;
            cur_byte_next   = data_bytes[0];
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Abort truncates whatever is on the line; bytes_sent keeps the last completed count.
    if (abort && state_reg != S_IDLE) begin
      state_next      = S_IDLE;
      tx_next         = 1'b1;
      done_next       = 1'b0;
      tick_next       = '0;
      bit_idx_next    = '0;
      gap_next        = '0;
      bytes_sent_next = bytes_sent_reg;
    end
  end

  assign tx_out     = tx_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = done_reg;
  assign bytes_sent = bytes_sent_reg;

endmodule
